// File: rtl/panel_pkg.sv
// rtl/panel_pkg.sv - shared constants and types for the per-panel frame store
package panel_pkg;

  localparam int PANEL_COUNT = 6;
  localparam int DEFAULT_ADDR_W = 12;
  localparam int DEFAULT_PIXEL_W = 16;

  localparam logic [15:0] SWAP_ADDR = 16'hFFFF;
  localparam logic [15:0] BRIGHT_ADDR = 16'hFFFE;

  typedef enum logic {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_t;

endpackage

// File: rtl/panel_bank_ram.sv
// rtl/panel_bank_ram.sv - simple dual-port RAM holding both pixel banks
module panel_bank_ram #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Only the output register is reset; the array itself keeps its contents.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/panel_framebuffer.sv
// rtl/panel_framebuffer.sv - double-buffered panel frame store with frame-synchronous bank swap
module panel_framebuffer
  import panel_pkg::*;
#(
  parameter int          PANEL_ID     = 0,
  parameter int          ADDR_W       = DEFAULT_ADDR_W,
  parameter int          PIXEL_W      = DEFAULT_PIXEL_W,
  parameter logic [7:0]  BRIGHT_RESET = 8'hFF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [5:0]         ctrl_en,
  input  logic [15:0]        ctrl_addr,
  input  logic [23:0]        ctrl_wdat,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [PIXEL_W-1:0] rd_data,
  input  logic               frame_done,
  output logic               front_bank,
  output logic               swap_pending,
  output logic [7:0]         brightness,
  output logic [15:0]        drop_count
);

  swap_state_t state, state_next;
  logic        sel;
  logic        pixel_hit;
  logic        swap_req;
  logic        bright_hit;
  logic        drop_hit;
  logic        toggle;
  logic        unused_wdat;

  assign sel        = ctrl_en[PANEL_ID];
  assign pixel_hit  = sel && (ctrl_addr[15:ADDR_W] == '0);
  assign swap_req   = sel && (ctrl_addr == SWAP_ADDR);
  assign bright_hit = sel && (ctrl_addr == BRIGHT_ADDR);
  assign drop_hit   = sel && !pixel_hit && !swap_req && !bright_hit;
  assign unused_wdat = ^ctrl_wdat;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= SWAP_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A frame_done that executes a swap can accept a fresh request in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      SWAP_IDLE:    if (swap_req) state_next = SWAP_PENDING;
      SWAP_PENDING: if (frame_done) state_next = swap_req ? SWAP_PENDING : SWAP_IDLE;
      default:      state_next = SWAP_IDLE;
    endcase
  end

  always_comb begin
    swap_pending = (state == SWAP_PENDING);
    toggle       = (state == SWAP_PENDING) && frame_done;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      front_bank <= 1'b0;
      brightness <= BRIGHT_RESET;
      drop_count <= '0;
    end else begin
      if (toggle) front_bank <= ~front_bank;
      if (bright_hit) brightness <= ctrl_wdat[7:0];
      if (drop_hit && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
    end
  end

  // Both ports use the registered front_bank, so a toggle edge sees pre-toggle banks.
  panel_bank_ram #(
    .ADDR_W (ADDR_W + 1),
    .DATA_W (PIXEL_W)
  ) u_ram (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (pixel_hit),
    .wr_addr ({~front_bank, ctrl_addr[ADDR_W-1:0]}),
    .wr_data (ctrl_wdat[PIXEL_W-1:0]),
    .rd_en   (rd_en),
    .rd_addr ({front_bank, rd_addr}),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_panel_framebuffer.sv
// tb/tb_panel_framebuffer.sv - directed self-checking bench for panel_framebuffer
module tb_panel_framebuffer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  ctrl_en = '0;
  logic [15:0] ctrl_addr = '0;
  logic [23:0] ctrl_wdat = '0;
  logic        rd_en = 1'b0;
  logic [11:0] rd_addr = '0;
  logic [15:0] rd_data;
  logic        frame_done = 1'b0;
  logic        front_bank;
  logic        swap_pending;
  logic [7:0]  brightness;
  logic [15:0] drop_count;

  int checks = 0;
  int passes = 0;

  panel_framebuffer #(
    .PANEL_ID     (0),
    .ADDR_W       (12),
    .PIXEL_W      (16),
    .BRIGHT_RESET (8'hFF)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .ctrl_en      (ctrl_en),
    .ctrl_addr    (ctrl_addr),
    .ctrl_wdat    (ctrl_wdat),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .frame_done   (frame_done),
    .front_bank   (front_bank),
    .swap_pending (swap_pending),
    .brightness   (brightness),
    .drop_count   (drop_count)
  );

  always #5 clock = ~clock;

  task automatic host_write(input logic [5:0] en, input logic [15:0] addr, input logic [23:0] wdat);
    @(negedge clock);
    ctrl_en = en;
    ctrl_addr = addr;
    ctrl_wdat = wdat;
    @(negedge clock);
    ctrl_en = '0;
  endtask

  task automatic pulse_frame();
    @(negedge clock);
    frame_done = 1'b1;
    @(negedge clock);
    frame_done = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] addr, output logic [15:0] data);
    @(negedge clock);
    rd_en = 1'b1;
    rd_addr = addr;
    @(negedge clock);
    rd_en = 1'b0;
    data = rd_data;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    checks++;
    if (front_bank !== 1'b0 || swap_pending !== 1'b0) $display("FAIL reset_fsm: got front=%b pend=%b expected 0/0", front_bank, swap_pending);
    else passes++;
    checks++;
    if (brightness !== 8'hFF || drop_count !== 16'h0000) $display("FAIL reset_regs: got bright=%h drops=%h expected ff/0000", brightness, drop_count);
    else passes++;
    checks++;
    if (rd_data !== 16'h0000) $display("FAIL reset_rd_data: got %h expected 0000", rd_data);
    else passes++;
  endtask

  task automatic test_basic_swap();
    logic [15:0] d;
    host_write(6'b000001, 16'h0010, 24'h001111);
    host_write(6'b000001, 16'hFFFF, 24'h000000);
    pulse_frame();
    host_write(6'b000001, 16'h0010, 24'h002222);
    host_write(6'b000001, 16'hFFFF, 24'h000000);
    pulse_frame();
    do_read(12'h010, d);
    checks++;
    if (d !== 16'h2222 || front_bank !== 1'b0) $display("FAIL basic_front0: got %h front=%b expected 2222 front=0", d, front_bank);
    else passes++;
    host_write(6'b000001, 16'h0010, 24'hABF800);
    do_read(12'h010, d);
    checks++;
    if (d !== 16'h2222) $display("FAIL basic_back_hidden: got %h expected 2222", d);
    else passes++;
    host_write(6'b000001, 16'hFFFF, 24'h000000);
    pulse_frame();
    do_read(12'h010, d);
    checks++;
    if (d !== 16'hF800 || front_bank !== 1'b1) $display("FAIL basic_after_swap: got %h front=%b expected f800 front=1", d, front_bank);
    else passes++;
  endtask

  task automatic test_other_panel();
    logic [15:0] d;
    host_write(6'b000001, 16'h0005, 24'h000A0A);
    host_write(6'b000010, 16'h0005, 24'h00BEEF);
    host_write(6'b111110, 16'h2000, 24'h000000);
    checks++;
    if (drop_count !== 16'h0000) $display("FAIL other_panel_drops: got %h expected 0000", drop_count);
    else passes++;
    host_write(6'b000001, 16'hFFFF, 24'h000000);
    pulse_frame();
    do_read(12'h005, d);
    checks++;
    if (d !== 16'h0A0A || front_bank !== 1'b0) $display("FAIL other_panel_ram: got %h front=%b expected 0a0a front=0", d, front_bank);
    else passes++;
  endtask

  task automatic test_swap_hold();
    int bad = 0;
    host_write(6'b000001, 16'hFFFF, 24'h000000);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (swap_pending !== 1'b1 || front_bank !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL swap_hold: got %0d bad cycles expected 0", bad);
    else passes++;
    pulse_frame();
    checks++;
    if (front_bank !== 1'b1 || swap_pending !== 1'b0) $display("FAIL swap_exec: got front=%b pend=%b expected 1/0", front_bank, swap_pending);
    else passes++;
  endtask

  task automatic test_double_swap();
    host_write(6'b000001, 16'hFFFF, 24'h000000);
    host_write(6'b000001, 16'hFFFF, 24'h000000);
    checks++;
    if (front_bank !== 1'b1 || swap_pending !== 1'b1) $display("FAIL swap_no_accum: got front=%b pend=%b expected 1/1", front_bank, swap_pending);
    else passes++;
    @(negedge clock);
    ctrl_en = 6'b000001;
    ctrl_addr = 16'hFFFF;
    frame_done = 1'b1;
    @(negedge clock);
    ctrl_en = '0;
    frame_done = 1'b0;
    checks++;
    if (front_bank !== 1'b0 || swap_pending !== 1'b1) $display("FAIL double_swap_queued: got front=%b pend=%b expected 0/1", front_bank, swap_pending);
    else passes++;
    pulse_frame();
    checks++;
    if (front_bank !== 1'b1 || swap_pending !== 1'b0) $display("FAIL double_swap_second: got front=%b pend=%b expected 1/0", front_bank, swap_pending);
    else passes++;
  endtask

  task automatic test_brightness();
    host_write(6'b000001, 16'hFFFE, 24'h000040);
    checks++;
    if (brightness !== 8'h40) $display("FAIL bright_set: got %h expected 40", brightness);
    else passes++;
    host_write(6'b000100, 16'hFFFE, 24'h000077);
    checks++;
    if (brightness !== 8'h40) $display("FAIL bright_other_panel: got %h expected 40", brightness);
    else passes++;
  endtask

  task automatic test_drops();
    host_write(6'b000001, 16'h2000, 24'h000000);
    checks++;
    if (drop_count !== 16'h0001) $display("FAIL drop_first: got %h expected 0001", drop_count);
    else passes++;
    host_write(6'b000001, 16'hFFFD, 24'h000000);
    checks++;
    if (drop_count !== 16'h0002 || swap_pending !== 1'b0) $display("FAIL drop_fffd: got %h pend=%b expected 0002 pend=0", drop_count, swap_pending);
    else passes++;
    @(negedge clock);
    ctrl_en = 6'b000001;
    ctrl_addr = 16'h2000;
    repeat (65532) @(negedge clock);
    checks++;
    if (drop_count !== 16'hFFFE) $display("FAIL drop_near_sat: got %h expected fffe", drop_count);
    else passes++;
    repeat (4) @(negedge clock);
    ctrl_en = '0;
    checks++;
    if (drop_count !== 16'hFFFF) $display("FAIL drop_saturate: got %h expected ffff", drop_count);
    else passes++;
  endtask

  task automatic test_reset_pending();
    host_write(6'b000001, 16'hFFFF, 24'h000000);
    checks++;
    if (swap_pending !== 1'b1 || front_bank !== 1'b1) $display("FAIL pre_reset_pending: got pend=%b front=%b expected 1/1", swap_pending, front_bank);
    else passes++;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (swap_pending !== 1'b0 || front_bank !== 1'b0 || brightness !== 8'hFF || drop_count !== 16'h0000)
      $display("FAIL reset_mid: got pend=%b front=%b bright=%h drops=%h expected 0/0/ff/0000", swap_pending, front_bank, brightness, drop_count);
    else passes++;
    pulse_frame();
    checks++;
    if (front_bank !== 1'b0 || swap_pending !== 1'b0) $display("FAIL reset_no_toggle: got front=%b pend=%b expected 0/0", front_bank, swap_pending);
    else passes++;
  endtask

  task automatic test_toggle_edge();
    logic [15:0] d;
    host_write(6'b000001, 16'hFFFF, 24'h000000);
    @(negedge clock);
    frame_done = 1'b1;
    rd_en = 1'b1;
    rd_addr = 12'h010;
    ctrl_en = 6'b000001;
    ctrl_addr = 16'h0020;
    ctrl_wdat = 24'h005A5A;
    @(negedge clock);
    frame_done = 1'b0;
    rd_en = 1'b0;
    ctrl_en = '0;
    checks++;
    if (rd_data !== 16'h2222 || front_bank !== 1'b1) $display("FAIL toggle_edge_read: got %h front=%b expected 2222 front=1", rd_data, front_bank);
    else passes++;
    repeat (3) @(negedge clock);
    checks++;
    if (rd_data !== 16'h2222) $display("FAIL rd_hold: got %h expected 2222", rd_data);
    else passes++;
    do_read(12'h020, d);
    checks++;
    if (d !== 16'h5A5A) $display("FAIL toggle_edge_write: got %h expected 5a5a", d);
    else passes++;
    do_read(12'h010, d);
    checks++;
    if (d !== 16'hF800) $display("FAIL front1_read: got %h expected f800", d);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_basic_swap();
    test_other_panel();
    test_swap_hold();
    test_double_swap();
    test_brightness();
    test_drops();
    test_reset_pending();
    test_toggle_edge();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/panel_framebuffer.md
Name: panel_framebuffer

Overview:
- Per-panel double-buffered frame store. Sits directly downstream of the UDP panel writer and consumes its ctrl_en/ctrl_addr/ctrl_wdat write strobes.
- One instance per panel; the instance responds only to bit PANEL_ID of ctrl_en.
- Host pixel writes always land in the back bank. The panel scan driver reads the front bank.
- A host swap command flips the banks, but only at the next scan frame boundary, so the display never tears.

Parameters:
- PANEL_ID, 0: which ctrl_en bit (0..5) selects this instance.
- ADDR_W, 12: pixel address width (4096 pixels, 64x64 panel).
- PIXEL_W, 16: stored pixel width, taken from ctrl_wdat[PIXEL_W-1:0].
- BRIGHT_RESET, 8'hFF: reset value of the brightness register.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ctrl_en  in  6  per-panel write strobe, one-cycle pulse
- ctrl_addr  in  16  pixel index or control-register address
- ctrl_wdat  in  24  write data
- rd_en  in  1  scan-side read request
- rd_addr  in  ADDR_W  scan-side pixel index
- rd_data  out  PIXEL_W  front-bank pixel, valid 1 cycle after rd_en
- frame_done  in  1  one-cycle pulse from the scanner at end of a frame
- front_bank  out  1  bank currently being displayed
- swap_pending  out  1  swap requested, not yet executed
- brightness  out  8  global brightness for the scanner
- drop_count  out  16  saturating count of rejected writes

Behaviour:
- Clock and reset: single clock `clock`. Reset `reset` is synchronous and active-high.
- Reset values: front_bank=0, swap_pending=0, brightness=BRIGHT_RESET, rd_data=0, drop_count=0. RAM contents are not cleared. A reset mid-operation discards any pending swap.
- Write decode: acts only when ctrl_en[PANEL_ID]=1. Other ctrl_en bits are ignored.
  - ctrl_addr < 2**ADDR_W: write ctrl_wdat[PIXEL_W-1:0] to the back bank (~front_bank) at ctrl_addr[ADDR_W-1:0] on that edge.
  - ctrl_addr == 16'hFFFF (SWAP_ADDR): swap request; ctrl_wdat is ignored.
  - ctrl_addr == 16'hFFFE (BRIGHT_ADDR): brightness <= ctrl_wdat[7:0] on that edge.
  - Any other address: write is dropped; drop_count increments and saturates at 16'hFFFF.
- Read path:
  - When rd_en=1, rd_data <= RAM[{front_bank, rd_addr}] on the next edge (1-cycle latency).
  - rd_data holds its value while rd_en=0.
  - Reads never return back-bank data.
- Swap FSM, states IDLE (swap_pending=0) and PENDING (swap_pending=1):
  - IDLE + swap request: go to PENDING on the next edge. A frame_done in the same cycle does not flip front_bank.
  - PENDING + frame_done: front_bank toggles and the FSM returns to IDLE on that edge.
  - PENDING + frame_done + new swap request in the same cycle: front_bank toggles and the FSM stays PENDING (the second swap is queued).
  - PENDING + swap request without frame_done: no change; requests do not accumulate beyond one.
- Bank switch timing: a pixel write and a bank toggle on the same edge write the pre-toggle back bank.
- Pixel writes while PENDING still target the current back bank. Sequencing writes after a swap is the host's responsibility.
- A read issued on the same edge as a toggle uses the pre-toggle front_bank.
- Throughput: one write and one read may occur every cycle, concurrently. There is no stall path; the upstream writer has no ready input.

Decomposition:
- Package panel_pkg holds:
  - PANEL_COUNT=6
  - SWAP_ADDR=16'hFFFF
  - BRIGHT_ADDR=16'hFFFE
  - the default ADDR_W and PIXEL_W
- Sub-module panel_bank_ram:
  - simple dual-port RAM: one write port, one registered read port
  - depth 2**(ADDR_W+1); the bank bit is the MSB of the address
  - written to infer block RAM; instantiated once.

Test Plan:
- Reset, then write pixel 0x0010 = 16'hF800 with ctrl_en=6'b000001 (PANEL_ID=0). Read 0x0010 -> rd_data is still the old/unknown front value. Swap, pulse frame_done, read again -> rd_data=16'hF800 one cycle after rd_en.
- ctrl_en=6'b000010 with addr 0x0005 on the PANEL_ID=0 instance -> no RAM change and drop_count stays 0.
- Write to 0xFFFF, hold frame_done low for 100 cycles -> swap_pending=1 and front_bank=0 throughout. Pulse frame_done -> front_bank=1 and swap_pending=0 on the next edge.
- While PENDING, assert a swap write and frame_done in the same cycle -> front_bank toggles and swap_pending remains 1. Next frame_done -> toggles back, swap_pending=0.
- Write to 0xFFFE with wdat 24'h000040 -> brightness=8'h40. Write to 0x2000 (out of range) -> drop_count=1. Force 65536 drops -> drop_count=16'hFFFF.
- Set PENDING, assert reset for 1 cycle -> swap_pending=0, front_bank=0, brightness=8'hFF. A later frame_done causes no toggle.
